// File: rtl/hilo_mdu_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply/divide unit.
interface hilo_mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src0;
  logic [31:0] src1;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  // Execute stage side: issues requests, reads HI/LO and status.
  modport master (
    output start, op, src0, src1,
    input  busy, done, hi, lo
  );

  // Unit side.
  modport slave (
    input  start, op, src0, src1,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_mdu.sv
// Iterative 32x32 multiply / 32/32 divide unit owning the HI/LO register pair.
// One shift-add or restoring-division step per cycle on operand magnitudes,
// with sign correction applied in a final FIX cycle.
module hilo_mdu (
  input logic       clk,
  input logic       rst_n,
  hilo_mdu_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        neg_lo_q;      // negate product, or negate quotient
  logic        neg_hi_q;      // negate remainder (follows dividend sign)
  logic        div_zero_q;
  logic [31:0] opnd_q;        // multiplicand or divisor magnitude
  logic [31:0] raw_src0_q;    // un-negated dividend for the divide-by-zero result
  logic [63:0] acc_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        accept, accept_iter, accept_mt;
  logic        signed_op;
  logic [31:0] abs0, abs1;
  logic [32:0] mul_sum, rem_sh, div_diff;
  logic [63:0] mul_next, div_next, prod;
  logic [31:0] fix_hi, fix_lo;

  // Request decode and operand magnitudes.
  always_comb begin
    accept      = (state_q == StIdle) && bus.start;
    accept_iter = accept && !bus.op[2];
    accept_mt   = accept && (bus.op == 3'd4 || bus.op == 3'd5);
    signed_op   = !bus.op[0];
    abs0        = (signed_op && bus.src0[31]) ? -bus.src0 : bus.src0;
    abs1        = (signed_op && bus.src1[31]) ? -bus.src1 : bus.src1;
  end

  // One iteration step: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    rem_sh   = {acc_q[63:32], acc_q[31]};
    div_diff = rem_sh - {1'b0, opnd_q};
    if (div_diff[32]) begin
      div_next = {rem_sh[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
    end
  end

  // Sign correction of the finished magnitude result.
  always_comb begin
    prod = neg_lo_q ? -acc_q : acc_q;
    if (!is_div_q) begin
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
    end else if (div_zero_q) begin
      fix_hi = raw_src0_q;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_hi = neg_hi_q ? -acc_q[63:32] : acc_q[63:32];
      fix_lo = neg_lo_q ? -acc_q[31:0] : acc_q[31:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept_iter) state_d = StRun;
      StRun:   if (cnt_q == 5'd31) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.busy = (state_q != StIdle);
    bus.done = done_q;
    bus.hi   = hi_q;
    bus.lo   = lo_q;
  end

  // Operand latch and iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 5'd0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= 32'd0;
      raw_src0_q <= 32'd0;
      acc_q      <= 64'd0;
    end else if (accept_iter) begin
      cnt_q      <= 5'd0;
      is_div_q   <= bus.op[1];
      neg_lo_q   <= signed_op && (bus.src0[31] ^ bus.src1[31]);
      neg_hi_q   <= signed_op && bus.src0[31];
      div_zero_q <= (bus.src1 == 32'd0);
      opnd_q     <= bus.op[1] ? abs1 : abs0;
      raw_src0_q <= bus.src0;
      acc_q      <= bus.op[1] ? {32'd0, abs0} : {32'd0, abs1};
    end else if (state_q == StRun) begin
      cnt_q <= cnt_q + 5'd1;
      acc_q <= is_div_q ? div_next : mul_next;
    end
  end

  // Architectural HI/LO and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == StFix) || accept_mt;
      if (state_q == StFix) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (accept_mt) begin
        if (bus.op[0]) lo_q <= bus.src0;
        else           hi_q <= bus.src0;
      end
    end
  end

endmodule
